// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the multi-cycle serial adder/subtractor.
// No logic; elaboration-time only.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

    // A single-step configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder, chained to form the per-cycle ripple slice.
// Purely combinational, zero latency, no backpressure.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Serial add/sub, BITS_PER_CYCLE bits per clock; result and done WIDTH/BITS_PER_CYCLE+1 cycles after start.
// start is only taken in IDLE or DONE; requests during RUN are dropped, never queued.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = calc_steps(WIDTH, BPC);
    localparam int CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, part_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    logic [BPC:0]         c;
    logic [BPC-1:0]       s;
    logic [WIDTH+BPC-1:0] shift_cat;
    logic [WIDTH-1:0]     part_next;
    logic                 accept, last;

    assign c[0] = carry_q;

    for (genvar i = 0; i < BPC; i++) begin : g_chain
        full_adder_cell u_cell (
            .a     (opa_q[i]),
            .b     (opb_q[i]),
            .cin   (c[i]),
            .sum   (s[i]),
            .carry (c[i+1])
        );
    end

    // New sum bits enter at the MSB end; after STEPS shifts bit 0 lands at the LSB.
    assign shift_cat = {s, part_q};
    assign part_next = shift_cat[WIDTH+BPC-1:BPC];

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            opa_q   <= opa_q >> BPC;
            opb_q   <= opb_q >> BPC;
            part_q  <= part_next;
            carry_q <= c[BPC];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                // c[BPC-1] is the carry into the MSB cell on the final slice.
                sum_q  <= part_next;
                cout_q <= c[BPC];
                ovf_q  <= c[BPC-1] ^ c[BPC];
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub across several WIDTH/BITS_PER_CYCLE builds.
// Index 0:(8,1) 1:(8,4) 2:(4,1) 3:(4,2) 4:(4,4).
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] start_v;
    logic [7:0] a, b;
    logic       cin, sub;
    logic [4:0] busy_v, done_v, cout_v, ovf_v;
    logic [7:0] s0, s1;
    logic [3:0] s2, s3, s4;
    logic [7:0] sum_w [5];
    int         st_tab [5] = '{8, 2, 4, 2, 1};
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .cout(cout_v[0]), .ovf(ovf_v[0]));
    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .cout(cout_v[1]), .ovf(ovf_v[1]));
    serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .cout(cout_v[2]), .ovf(ovf_v[2]));
    serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .cout(cout_v[3]), .ovf(ovf_v[3]));
    serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .a(a[3:0]), .b(b[3:0]), .cin(cin), .sub(sub),
        .busy(busy_v[4]), .done(done_v[4]), .sum(s4), .cout(cout_v[4]), .ovf(ovf_v[4]));

    assign sum_w[0] = s0;
    assign sum_w[1] = s1;
    assign sum_w[2] = {4'b0, s2};
    assign sum_w[3] = {4'b0, s3};
    assign sum_w[4] = {4'b0, s4};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum[7:0]} for a w-bit operation.
    function automatic logic [9:0] model(input int w, input int av, input int bv,
                                         input logic ci, input logic sb);
        int mask, bb, r, sm, co, ov;
        mask = (1 << w) - 1;
        bb   = sb ? (~bv & mask) : bv;
        r    = av + bb + ((sb || ci) ? 1 : 0);
        sm   = r & mask;
        co   = (r >> w) & 1;
        ov   = ((((av >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
                (((sm >> (w-1)) & 1) != ((av >> (w-1)) & 1))) ? 1 : 0;
        return {ov[0], co[0], sm[7:0]};
    endfunction

    // Called #1 after an edge; returns #1 after the edge that samples start.
    task automatic start_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                            input logic ci, input logic sb);
        a = av; b = bv; cin = ci; sub = sb;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input logic hold_en, input logic [7:0] held,
                             input logic meddle);
        int cyc = 1;
        int bsy = 0;
        while (!done_v[d] && cyc < 64) begin
            if (busy_v[d]) bsy++;
            if (hold_en) chk("hold", sum_w[d], held);
            if (meddle) begin
                if (cyc == 1) begin
                    start_v[d] = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
                end else begin
                    start_v[d] = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, st_tab[d] + 1);
        chk("busy_cycles", bsy, st_tab[d]);
        chk("busy_in_done", busy_v[d], 0);
    endtask

    task automatic chk_res(input int d, input logic [7:0] es, input logic ec, input logic eo);
        chk("sum", sum_w[d], es);
        chk("cout", cout_v[d], ec);
        chk("ovf", ovf_v[d], eo);
    endtask

    initial begin
        logic [9:0] m;
        rst_n = 1'b0; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 5; d++) begin
            chk("rst_busy", busy_v[d], 0);
            chk("rst_done", done_v[d], 0);
            chk_res(d, 8'h00, 1'b0, 1'b0);
        end
        @(posedge clk); #1;

        start_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_done(0, 1'b0, 8'h00, 1'b0);
        chk_res(0, 8'h96, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("done_pulse", done_v[0], 0);

        start_op(0, 8'hFF, 8'h01, 1'b1, 1'b0);
        wait_done(0, 1'b0, 8'h00, 1'b0);
        chk_res(0, 8'h01, 1'b1, 1'b0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        start_op(0, 8'h10, 8'h20, 1'b1, 1'b1);
        wait_done(0, 1'b0, 8'h00, 1'b0);
        chk_res(0, 8'hF0, 1'b0, 1'b0);
        start_op(0, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(0, 1'b1, 8'hF0, 1'b0);
        chk_res(0, 8'h7F, 1'b1, 1'b1);
        @(posedge clk); #1;

        // Restart and operand change during RUN must be ignored.
        start_op(1, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(1, 1'b0, 8'h00, 1'b1);
        chk_res(1, 8'h46, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("no_requeue", busy_v[1], 0);

        start_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", busy_v[1], 0);
        chk("midrst_done", done_v[1], 0);
        chk_res(1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_nodone", done_v[1] | busy_v[1], 0);
            @(posedge clk); #1;
        end

        for (int d = 2; d < 5; d++) begin
            for (int av = 0; av < 16; av++) begin
                for (int bv = 0; bv < 16; bv++) begin
                    for (int mode = 0; mode < 4; mode++) begin
                        m = model(4, av, bv, mode[0], mode[1]);
                        start_op(d, 8'(av), 8'(bv), mode[0], mode[1]);
                        wait_done(d, 1'b0, 8'h00, 1'b0);
                        chk_res(d, m[7:0], m[8], m[9]);
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands, BITS_PER_CYCLE bits per clock, through a ripple chain of one-bit full-adder cells.
- Uses a start/done handshake.
- Provides the area-cheap arithmetic datapath for control-path blocks where latency is acceptable.

Parameters:
- WIDTH, 8: operand and result width in bits; must be 2 or more.
- BITS_PER_CYCLE, 1: bits processed per clock. WIDTH mod BITS_PER_CYCLE must be 0. Elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched on an accepted start.
- b  input  WIDTH  operand B; latched on an accepted start.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  mode: 0 computes a+b+cin; 1 computes a-b, implemented as a+~b+1.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB xor carry out of MSB.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low: rst_n low at a rising edge resets everything.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers and step counter=0.
- STEPS = WIDTH/BITS_PER_CYCLE.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch a into opA.
  - Latch b into opB, or ~b when sub=1.
  - Carry register := sub ? 1 : cin.
  - Step counter := 0. Next state = RUN.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - The low BITS_PER_CYCLE bits of opA/opB plus the carry register feed the cell chain.
  - Chain sum bits shift into the MSB end of the partial-result register. opA/opB shift right by BITS_PER_CYCLE.
  - Carry register := chain carry-out. Counter increments.
  - On the step where counter = STEPS-1, also capture the carry into the MSB cell.
  - After that step, next state = DONE.
- Entering DONE: sum, cout and ovf load in the same edge. done=1 for exactly the DONE cycle.
- Output hold: sum, cout and ovf hold until the next result load. They do not change during a following RUN.
- Latency: start sampled at edge k gives busy=1 in cycles k+1 .. k+STEPS and done=1 in cycle k+STEPS+1.
- Back-to-back: start asserted during DONE is accepted, so throughput is one result per STEPS+1 cycles.
- start while busy (RUN): ignored; operands are not re-latched and the op is not queued.
- Changes to a, b, cin or sub during RUN have no effect.
- Reset mid-RUN: abort to IDLE, clear all state, no done pulse.
- done and busy are never high together.
- Widths: all arithmetic is modulo 2^WIDTH. cout and ovf carry the out-of-range information.

Decomposition:
- Package serial_addsub_pkg:
  - state enum (IDLE, RUN, DONE);
  - function computing STEPS and the step-counter width, $clog2(STEPS) with a minimum of 1.
- Sub-module full_adder_cell (a, b, cin -> sum, carry): one-bit full adder, instantiated BITS_PER_CYCLE times in a generate loop to form the per-cycle ripple chain.
- The top level holds the FSM, shift registers and result registers.

Test Plan:
- Add, WIDTH=8, BPC=1: a=0x5A, b=0x3C, cin=0, sub=0 -> sum=0x96, cout=0, ovf=1. done exactly 9 cycles after the start edge; busy high for 8 cycles.
- Add with carry-in, WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
- Subtract, WIDTH=8, BPC=1:
  - a=0x10, b=0x20, sub=1, cin=1 (ignored) -> sum=0xF0, cout=0, ovf=0.
  - Back-to-back start in the DONE cycle: a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
  - The first result holds during the second RUN.
- Protocol, WIDTH=8, BPC=4:
  - start pulsed again and a changed during RUN -> ignored; result reflects the original operands; done at start edge +3.
  - rst_n=0 mid-RUN -> IDLE, all outputs 0, no done.
- Exhaustive, WIDTH=4 and BPC in {1,2,4}: all a, b, cin, sub combinations -> sum, cout and ovf match the reference model; done exactly STEPS+1 cycles after each start.
